// File: rtl/md_defs.sv
// md_defs: op and state encodings shared by md_unit and the hazard unit
package md_defs;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_MUL   = 2'd1;
  localparam logic [1:0] MD_DIV_S = 2'd2;
endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers
module md_unit
  import md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ignored
);
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   ra, rb, ma, mb, mb_safe, uq, ur, q, r;
  logic [2*WIDTH-1:0] ea, eb, prod;
  logic               sgn, a_neg, b_neg, dz;
  // Arithmetic from latched operands: sign-extended product, magnitude divide with sign fix-up
  always_comb begin
    a_neg   = sgn & ra[WIDTH-1];
    b_neg   = sgn & rb[WIDTH-1];
    ea      = {{WIDTH{a_neg}}, ra};
    eb      = {{WIDTH{b_neg}}, rb};
    prod    = ea * eb;
    ma      = a_neg ? -ra : ra;
    mb      = b_neg ? -rb : rb;
    dz      = rb == '0;
    mb_safe = dz ? WIDTH'(1) : mb;
    uq      = ma / mb_safe;
    ur      = ma % mb_safe;
    q       = (a_neg ^ b_neg) ? -uq : uq;
    r       = a_neg ? -ur : ur;
  end
  assign busy = state != MD_IDLE;
  // Control FSM with inline latency counter, HI/LO update at commit or MTHI/MTLO
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      ignored <= 1'b0;
      ra      <= '0;
      rb      <= '0;
      sgn     <= 1'b0;
    end else begin
      ignored <= start && busy;
      if (!busy) begin
        if (start && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU)) begin
          state <= op[1] ? MD_DIV_S : MD_MUL;
          cnt   <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          ra    <= a;
          rb    <= b;
          sgn   <= !op[0];
        end else if (start && op == MD_MTHI) hi <= a;
        else if (start && op == MD_MTLO) lo <= a;
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state <= MD_IDLE;
          if (state == MD_MUL) {hi, lo} <= prod;
          else if (!dz) begin
            hi <= r;
            lo <= q;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit
module tb_md_unit;
  import md_defs::*;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] a = '0, b = '0;
  logic        busy, ignored;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, bcnt = 0, ign_cnt = 0;
  logic prev_busy = 1'b0;
  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .ignored(ignored)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  // Monitor: count busy/ignored cycles and check each completed operation against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (ignored === 1'b1) ign_cnt++;
    if (busy === 1'b1) bcnt++;
    else if (prev_busy === 1'b1) begin
      if (reset !== 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit: got hi=%h lo=%h want none", hi, lo);
        end else begin
          e = sb.pop_front();
          chk("result_hi", hi, e.hi);
          chk("result_lo", lo, e.lo);
          chk("busy_cycles", 32'(bcnt), 32'(e.lat));
        end
      end
      bcnt = 0;
    end
    prev_busy = busy;
  end
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'd7;
    a = ~x;
    b = ~y;
  endtask
  task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.lat = n;
    sb.push_back(e);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 40);
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy=%b want 0", busy);
    end
  endtask
  initial begin
    int ign0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ignored", 32'(ignored), 32'h0);
    push(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle();
    push(32'h00000001, 32'hFFFFFFFE, 5);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle();
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    push(32'd1, 32'd3, 10);
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle();
    push(32'h0, 32'h80000000, 10);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    issue(MD_MTHI, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'h80000000);
    chk("mthi_busy", 32'(busy), 32'h0);
    issue(MD_MTLO, 32'hAAAA0000, 32'h0);
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hAAAA0000);
    chk("mtlo_busy", 32'(busy), 32'h0);
    push(32'h12345678, 32'hAAAA0000, 10);
    issue(MD_DIVU, 32'd5, 32'd0);
    wait_idle();
    ign0 = ign_cnt;
    push(32'hFFFFFFFF, 32'hFFFFFFF4, 5);
    issue(MD_MULT, 32'd3, 32'hFFFFFFFC);
    @(posedge clk);
    #1;
    issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
    wait_idle();
    chk("ignored_pulses", 32'(ign_cnt - ign0), 32'd1);
    chk("ignored_hi_kept", hi, 32'hFFFFFFFF);
    issue(MD_DIVU, 32'd100, 32'd3);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    repeat (12) @(negedge clk);
    chk("postreset_hi", hi, 32'h0);
    chk("postreset_lo", lo, 32'h0);
    chk("postreset_busy", 32'(busy), 32'h0);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
